// File: rtl/modular_inverse.sv
// modular_inverse: binary extended Euclid inverse of a modulo the odd prime P.
// One FSM state per cycle; results are held while Start stays high.
module modular_inverse #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [255:0] a,
  output logic         Done,
  output logic         Error,
  output logic [255:0] inverse
);
  typedef enum logic [2:0] {IDLE, LOAD, HALVE_U, HALVE_V, SUB, FINISH, FAIL} state_t;
  state_t state_q, state_d;
  logic [255:0] a_q, a_d, u_q, u_d, v_q, v_d, a_red;
  logic [256:0] x1_q, x1_d, x2_q, x2_d;
  logic         one;
  function automatic logic [256:0] half_mod(input logic [256:0] x);
    half_mod = x[0] ? (x + {1'b0, P}) >> 1 : x >> 1;
  endfunction
  // Negative differences wrap back into [0,P-1] by adding P once.
  function automatic logic [256:0] sub_mod(input logic [256:0] x, input logic [256:0] y);
    logic [257:0] d;
    d = {1'b0, x} - {1'b0, y};
    sub_mod = d[257] ? d[256:0] + {1'b0, P} : d[256:0];
  endfunction
  assign a_red = a_q >= P ? a_q - P : a_q;
  assign one = u_q == 256'd1 || v_q == 256'd1;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    u_d = u_q;
    v_d = v_q;
    x1_d = x1_q;
    x2_d = x2_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = LOAD;
        a_d = a;
      end
      LOAD: begin
        u_d = a_red;
        v_d = P;
        x1_d = 257'd1;
        x2_d = '0;
        state_d = a_red == '0 ? FAIL : HALVE_U;
      end
      HALVE_U: if (one) state_d = FINISH;
        else if (!u_q[0]) begin
          u_d = u_q >> 1;
          x1_d = half_mod(x1_q);
        end else state_d = HALVE_V;
      HALVE_V: if (!v_q[0]) begin
          v_d = v_q >> 1;
          x2_d = half_mod(x2_q);
        end else state_d = SUB;
      SUB: begin
        if (u_q >= v_q) begin
          u_d = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q);
        end else begin
          v_d = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q);
        end
        state_d = HALVE_U;
      end
      FINISH, FAIL: if (!Start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q <= '0;
      u_q <= '0;
      v_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      u_q <= u_d;
      v_q <= v_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end
  assign Done = !Reset && (state_q == FINISH || state_q == FAIL);
  assign Error = !Reset && state_q == FAIL;
  assign inverse = (!Reset && state_q == FINISH) ? (u_q == 256'd1 ? x1_q[255:0] : x2_q[255:0]) : '0;
endmodule

// File: tb/tb_modular_inverse.sv
// tb_modular_inverse: directed and product-checked vectors for modular_inverse.
module tb_modular_inverse;
  localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] INV2 = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;
  logic Clk = 0, Reset = 1, Start = 0, Done, Error;
  logic [255:0] a = '0, inverse, ra;
  logic [511:0] pr;
  int n_pass = 0, n_tot = 0, cyc;
  modular_inverse #(.P(P)) dut (.Clk(Clk), .Reset(Reset), .Start(Start), .a(a),
    .Done(Done), .Error(Error), .inverse(inverse));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [255:0] av);
    Start = 1;
    a = av;
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!Done && cyc < 1200);
    chk({tag, "_done_in_time"}, 256'(Done && cyc <= 1100), 256'd1);
  endtask
  task automatic release_start(input string tag);
    Start = 0;
    step(1);
    chk({tag, "_idle_done"}, 256'(Done), 256'd0);
    chk({tag, "_idle_inv"}, inverse, '0);
  endtask
  task automatic prod_chk(input string tag, input logic [255:0] av);
    run(tag, av);
    pr = {256'b0, av} * {256'b0, inverse};
    pr = pr % {256'b0, P};
    chk({tag, "_product"}, pr[255:0], 256'd1);
    chk({tag, "_err"}, 256'(Error), 256'd0);
    release_start(tag);
  endtask
  initial begin
    step(1);
    chk("rst_done", 256'(Done), 256'd0);
    chk("rst_err", 256'(Error), 256'd0);
    chk("rst_inv", inverse, '0);
    step(1);
    Reset = 0;
    step(1);
    chk("post_rst_done", 256'(Done), 256'd0);
    // a=1 must finish after exactly Load, HalveU, Finish
    Start = 1;
    a = 256'd1;
    step(2);
    chk("a1_early", 256'(Done), 256'd0);
    step(1);
    chk("a1_done", 256'(Done), 256'd1);
    chk("a1_inv", inverse, 256'd1);
    chk("a1_err", 256'(Error), 256'd0);
    step(3);
    chk("a1_hold_done", 256'(Done), 256'd1);
    chk("a1_hold_inv", inverse, 256'd1);
    release_start("a1");
    // operand changes and Start held after capture must not disturb the run
    Start = 1;
    a = 256'd2;
    step(1);
    a = 256'h1234_5678_9ABC_DEF0;
    run("a2", a);
    chk("a2_inv", inverse, INV2);
    chk("a2_err", 256'(Error), 256'd0);
    release_start("a2");
    run("pm1", P - 256'd1);
    chk("pm1_inv", inverse, P - 256'd1);
    release_start("pm1");
    run("pp1", P + 256'd1);
    chk("pp1_inv", inverse, 256'd1);
    release_start("pp1");
    run("pp2", P + 256'd2);
    chk("pp2_inv", inverse, INV2);
    release_start("pp2");
    prod_chk("a3", 256'd3);
    prod_chk("amax", {256{1'b1}});
    run("a0", '0);
    chk("a0_done", 256'(Done), 256'd1);
    chk("a0_err", 256'(Error), 256'd1);
    chk("a0_inv", inverse, '0);
    release_start("a0");
    run("aP", P);
    chk("aP_err", 256'(Error), 256'd1);
    chk("aP_inv", inverse, '0);
    release_start("aP");
    // reset in the middle of an a=3 run, with Start still high
    Start = 1;
    a = 256'd3;
    step(6);
    Reset = 1;
    step(1);
    chk("mid_rst_done", 256'(Done), 256'd0);
    chk("mid_rst_inv", inverse, '0);
    Reset = 0;
    Start = 0;
    step(1);
    chk("after_rst_done", 256'(Done), 256'd0);
    chk("after_rst_err", 256'(Error), 256'd0);
    step(20);
    chk("after_rst_quiet", 256'(Done), 256'd0);
    run("rst_a2", 256'd2);
    chk("rst_a2_inv", inverse, INV2);
    release_start("rst_a2");
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (ra >= P) ra = ra - P;
      if (ra == '0) ra = 256'd1;
      prod_chk("rand", ra);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
